// File: rtl/pc_seq_unit.sv
// pc_seq_unit: fetch PC sequencer with stall-time redirect capture; define PC_ALIGN_CHECK_EN to trap misaligned targets
module pc_seq_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h0000_0180),
  parameter int STEP = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             exc,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             pc_valid,
  output logic             redir_pend,
  output logic             addr_err
);
  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, HOLD = 2'd2;
  logic [1:0] r_state;
  logic [WIDTH-1:0] r_pc, r_pend_tgt, w_tgt;
  logic r_pend, r_pend_br, r_addr_err, w_redir, w_mis;
  assign pc = r_pc;
  assign pc_plus = r_pc + WIDTH'(STEP);
  assign pc_valid = r_state != BOOT;
  assign redir_pend = r_pend;
  assign addr_err = r_addr_err;
  // redirect target on release: live branch, then live jump, then whatever was captured while stalled
  always_comb begin
    w_tgt = br_taken ? br_target : jmp ? jmp_target : r_pend_tgt;
    w_redir = br_taken | jmp | r_pend;
  end
`ifdef PC_ALIGN_CHECK_EN
  localparam logic [WIDTH-1:0] MASK = WIDTH'(STEP - 1);
  assign w_mis = w_redir && |(w_tgt & MASK);
`else
  assign w_mis = 1'b0;
`endif
  // state, pc and pending-redirect update; a pending branch is never displaced by a later jump
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc <= RESET_VECTOR;
      r_pend <= 1'b0;
      r_pend_br <= 1'b0;
      r_pend_tgt <= '0;
      r_addr_err <= 1'b0;
    end else if (exc) begin
      r_state <= RUN;
      r_pc <= EXC_VECTOR;
      r_pend <= 1'b0;
      r_pend_br <= 1'b0;
      r_addr_err <= 1'b0;
    end else if (r_state == BOOT) begin
      r_state <= stall ? HOLD : RUN;
      r_addr_err <= 1'b0;
    end else if (stall) begin
      r_state <= HOLD;
      r_addr_err <= 1'b0;
      if (br_taken) begin
        r_pend <= 1'b1;
        r_pend_br <= 1'b1;
        r_pend_tgt <= br_target;
      end else if (jmp && !(r_pend && r_pend_br)) begin
        r_pend <= 1'b1;
        r_pend_br <= 1'b0;
        r_pend_tgt <= jmp_target;
      end
    end else begin
      r_state <= RUN;
      r_pc <= w_mis ? EXC_VECTOR : w_redir ? w_tgt : pc_plus;
      r_pend <= 1'b0;
      r_pend_br <= 1'b0;
      r_addr_err <= w_mis;
    end
  end
endmodule

// File: tb/tb_pc_seq_unit.sv
// tb_pc_seq_unit: directed plus random checks of pc_seq_unit against a rule-level reference model
module tb_pc_seq_unit;
  logic clk, reset, stall, exc, br_taken, jmp;
  logic [31:0] br_target, jmp_target, pc, pc_plus;
  logic pc_valid, redir_pend, addr_err;
  int vectors = 0, miscompares = 0;
  logic [31:0] m_pc, m_ptgt;
  bit m_boot, m_pend, m_pend_br, m_err;

  pc_seq_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .exc(exc),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .pc(pc), .pc_plus(pc_plus), .pc_valid(pc_valid), .redir_pend(redir_pend), .addr_err(addr_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic bit misaligned(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    logic [31:0] t;
    bit has;
    m_err = 0;
    if (reset) begin
      m_pc = 32'h0; m_boot = 1; m_pend = 0; m_pend_br = 0; m_ptgt = 0;
    end else if (exc) begin
      m_pc = 32'h180; m_boot = 0; m_pend = 0; m_pend_br = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (stall) begin
      if (br_taken) begin
        m_pend = 1; m_pend_br = 1; m_ptgt = br_target;
      end else if (jmp && !(m_pend && m_pend_br)) begin
        m_pend = 1; m_pend_br = 0; m_ptgt = jmp_target;
      end
    end else begin
      has = 1;
      if (br_taken) t = br_target;
      else if (jmp) t = jmp_target;
      else if (m_pend) t = m_ptgt;
      else has = 0;
      if (!has) m_pc = m_pc + 32'd4;
      else if (misaligned(t)) begin
        m_pc = 32'h180; m_err = 1;
      end else m_pc = t;
      m_pend = 0; m_pend_br = 0;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_plus"}, pc_plus, m_pc + 32'd4);
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(!m_boot));
    check({tag, ".redir_pend"}, 32'(redir_pend), 32'(m_pend));
    check({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
  endtask

  task automatic drive(input bit s, input bit e, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt);
    stall = s; exc = e; br_taken = b; br_target = bt; jmp = j; jmp_target = jt;
  endtask

  initial begin
    reset = 1;
    drive(0, 0, 0, 0, 0, 0);
    m_pc = 0; m_ptgt = 0; m_boot = 1; m_pend = 0; m_pend_br = 0; m_err = 0;
    step("rst0");
    step("rst1");
    check("rst_pc", pc, 32'h0);
    check("rst_valid", 32'(pc_valid), 32'h0);
    reset = 0;
    step("boot");
    check("boot_pc", pc, 32'h0);
    check("boot_valid", 32'(pc_valid), 32'h1);
    for (int i = 0; i < 4; i++) step("seq");
    check("seq_pc", pc, 32'h10);
    drive(0, 0, 1, 32'h100, 1, 32'h200);
    step("prio");
    check("prio_pc", pc, 32'h100);
    drive(0, 0, 0, 0, 1, 32'h20);
    step("jmp20");
    drive(1, 0, 0, 0, 1, 32'h400);
    step("stall1");
    drive(1, 0, 0, 0, 0, 0);
    step("stall2");
    step("stall3");
    check("stall_hold", pc, 32'h20);
    check("stall_pend", 32'(redir_pend), 32'h1);
    drive(0, 0, 0, 0, 0, 0);
    step("release");
    check("release_pc", pc, 32'h400);
    check("release_pend", 32'(redir_pend), 32'h0);
    drive(1, 0, 0, 0, 1, 32'h400);
    step("pend_j");
    drive(1, 1, 0, 0, 0, 0);
    step("exc");
    check("exc_pc", pc, 32'h180);
    check("exc_pend", 32'(redir_pend), 32'h0);
    drive(1, 0, 1, 32'h300, 0, 0);
    step("cap_br");
    drive(1, 0, 0, 0, 1, 32'h500);
    step("cap_j_after_br");
    drive(0, 0, 0, 0, 0, 0);
    step("rel_br");
    check("keep_br", pc, 32'h300);
    drive(1, 0, 0, 0, 1, 32'h600);
    step("cap_j");
    drive(1, 0, 1, 32'h700, 0, 0);
    step("cap_br_over_j");
    drive(0, 0, 0, 0, 0, 0);
    step("rel_j");
    check("br_over_j", pc, 32'h700);
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    step("jtop");
    check("top_plus", pc_plus, 32'h0);
    drive(0, 0, 0, 0, 0, 0);
    step("wrap");
    check("wrap_pc", pc, 32'h0);
    drive(0, 0, 1, 32'h102, 0, 0);
    step("mis");
`ifdef PC_ALIGN_CHECK_EN
    check("mis_pc", pc, 32'h180);
    check("mis_err", 32'(addr_err), 32'h1);
`else
    check("mis_pc", pc, 32'h102);
    check("mis_err", 32'(addr_err), 32'h0);
`endif
    drive(0, 0, 0, 0, 0, 0);
    step("mis_after");
    check("err_pulse", 32'(addr_err), 32'h0);
    drive(1, 0, 0, 0, 1, 32'h800);
    step("pre_rst");
    reset = 1;
    step("rst_mid");
    check("rst_mid_pend", 32'(redir_pend), 32'h0);
    reset = 0;
    step("boot_stall");
    drive(0, 0, 0, 0, 0, 0);
    step("boot_rel");
    check("boot_rel_pc", pc, 32'h4);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] bt, jt;
      bt = $urandom & 32'hFFFF_FFFC;
      jt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) bt = bt | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) jt = jt | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) jt = 32'hFFFF_FFF0;
      reset = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0, $urandom_range(0, 4) == 0, bt,
            $urandom_range(0, 4) == 0, jt);
      step("rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
